manual_time_set: RTL and testbench

Manual time-setting front end for the digital clock: the producer of the `manual_*` BCD digits that the 1 Hz time counter loads while the board is in time-set mode. It runs on the fast system clock and debounces the select, increment and decrement push-buttons. It walks a field selector over seconds/minutes/hours and edits the selected field in BCD with wrap-around. While time-set mode is inactive, it tracks the counter's current time, so that entering the mode starts from the displayed time.

---
 rtl/clock_pkg.sv | 45 ++++
 rtl/btn_debounce.sv | 77 +++++++
 rtl/manual_time_set.sv | 197 +++++++++++++++++++
 tb/tb_manual_time_set.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared definitions for the digital clock: time-field
//               encoding, BCD limits and the power-on / reset time.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    // Field selector encoding, also used directly as the field FSM states
    typedef enum logic [1:0] {
        FIELD_SEC  = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_HOUR = 2'd2
    } field_e;

    // BCD limits
    localparam logic [3:0] BCD_MAX_L  = 4'd9;
    localparam logic [3:0] SEC_MAX_H  = 4'd5;
    localparam logic [3:0] HOUR_MAX_H = 4'd2;
    localparam logic [3:0] HOUR_MAX_L = 4'd3;

    // Reset time 23:57:00, shared with the time counter's reset
    localparam logic [3:0] RST_HOUR_H = 4'd2;
    localparam logic [3:0] RST_HOUR_L = 4'd3;
    localparam logic [3:0] RST_MIN_H  = 4'd5;
    localparam logic [3:0] RST_MIN_L  = 4'd7;
    localparam logic [3:0] RST_SEC_H  = 4'd0;
    localparam logic [3:0] RST_SEC_L  = 4'd0;

    // Full time of day as six BCD digits, most significant first
    typedef struct packed {
        logic [3:0] hour_h;
        logic [3:0] hour_l;
        logic [3:0] min_h;
        logic [3:0] min_l;
        logic [3:0] sec_h;
        logic [3:0] sec_l;
    } bcd_time_t;

    localparam bcd_time_t RST_TIME = {RST_HOUR_H, RST_HOUR_L, RST_MIN_H,
                                      RST_MIN_L, RST_SEC_H, RST_SEC_L};

endpackage : clock_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Push-button conditioner: 2-FF synchronizer, stability
//               counter and a single-cycle pulse on the debounced rising
//               edge. Latency from a clean raw edge to the pulse is
//               2 + DEBOUNCE_CYCLES clocks. After reset the button must be
//               seen released before any press is reported.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q,   sync_d;    // [0] first stage, [1] second stage
    logic [1:0]       valid_q,  valid_d;   // marks synchronizer stages holding real samples
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             stable_q, stable_d;  // debounced level
    logic             armed_q,  armed_d;   // a release has been seen since reset
    logic             pulse_q,  pulse_d;

    // Synchronize, count stable cycles, flip the debounced level, emit the pulse
    always_comb begin
        sync_d   = {sync_q[0], btn_raw};
        valid_d  = {valid_q[0], 1'b1};
        stable_d = stable_q;
        cnt_d    = '0;
        armed_d  = armed_q;
        pulse_d  = 1'b0;

        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A button held through reset stays unarmed until it is let go
        if (valid_q[1] && !sync_q[1] && !stable_q) begin
            armed_d = 1'b1;
        end

        pulse_d = armed_q && stable_d && !stable_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            valid_q  <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            armed_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            armed_q  <= armed_d;
            pulse_q  <= pulse_d;
        end
    end

    assign btn_pulse = pulse_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/manual_time_set.sv
`default_nettype none
// ============================================================================
// Module      : manual_time_set
// Description : Manual time-setting front end. Tracks the counter time while
//               time-set mode is off; in time-set mode walks a field selector
//               (sec/min/hour) and edits the selected field in BCD with wrap.
//               Optional macro MANUAL_SET_DEC_EN enables the decrement button.
// Revision    : 1.0 - initial release
// ============================================================================
module manual_time_set
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw0,
    input  logic       sw1,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [3:0] self_secL,
    input  logic [3:0] self_secH,
    input  logic [3:0] self_minL,
    input  logic [3:0] self_minH,
    input  logic [3:0] self_hourL,
    input  logic [3:0] self_hourH,
    output logic [3:0] manual_secL,
    output logic [3:0] manual_secH,
    output logic [3:0] manual_minL,
    output logic [3:0] manual_minH,
    output logic [3:0] manual_hourL,
    output logic [3:0] manual_hourH,
    output logic [1:0] field_sel
);

    // Step a two-digit BCD pair up or down with wrap between 00 and max.
    // Out-of-range or non-BCD input snaps to 00 (up) or to max (down).
    function automatic logic [7:0] bcd_pair_step(
        input logic [7:0] pair,
        input logic [3:0] max_h,
        input logic [3:0] max_l,
        input logic       up
    );
        logic [3:0] h;
        logic [3:0] l;
        logic       invalid;
        logic [7:0] res;
        h       = pair[7:4];
        l       = pair[3:0];
        invalid = (l > BCD_MAX_L) || (h > max_h) || ((h == max_h) && (l > max_l));
        if (invalid) begin
            res = up ? 8'h00 : {max_h, max_l};
        end else if (up) begin
            if ((h == max_h) && (l == max_l)) begin
                res = 8'h00;
            end else if (l == BCD_MAX_L) begin
                res = {h + 4'd1, 4'd0};
            end else begin
                res = {h, l + 4'd1};
            end
        end else begin
            if ((h == 4'd0) && (l == 4'd0)) begin
                res = {max_h, max_l};
            end else if (l == 4'd0) begin
                res = {h - 4'd1, BCD_MAX_L};
            end else begin
                res = {h, l - 4'd1};
            end
        end
        return res;
    endfunction

    logic      sel_pulse;
    logic      inc_pulse;
    logic      dec_pulse;

    logic      set_active_q, set_active_d;
    bcd_time_t trk1_q,       trk1_d;
    bcd_time_t trk2_q,       trk2_d;
    bcd_time_t manual_q,     manual_d;
    field_e    field_q,      field_d;

    logic      edit_sel;
    logic      edit_inc;
    logic      edit_dec;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sel_db (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_sel),
        .btn_pulse (sel_pulse)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_inc_db (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_inc),
        .btn_pulse (inc_pulse)
    );

`ifdef MANUAL_SET_DEC_EN
    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dec_db (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_dec),
        .btn_pulse (dec_pulse)
    );
`else
    // Decrement disabled: the port exists for board compatibility only
    logic unused_btn_dec;
    assign unused_btn_dec = btn_dec;
    assign dec_pulse      = 1'b0;
`endif

    // Qualify button pulses: only act while editing; inc+dec together cancel
    always_comb begin
        edit_sel = set_active_q && sel_pulse;
        edit_inc = set_active_q && inc_pulse && !dec_pulse;
        edit_dec = set_active_q && dec_pulse && !inc_pulse;
    end

    // Field selector FSM: SEC -> MIN -> HOUR -> SEC on each select while editing
    always_comb begin
        field_d = field_q;
        if (!set_active_q) begin
            field_d = FIELD_SEC;
        end else if (edit_sel) begin
            case (field_q)
                FIELD_SEC:  field_d = FIELD_MIN;
                FIELD_MIN:  field_d = FIELD_HOUR;
                FIELD_HOUR: field_d = FIELD_SEC;
                default:    field_d = FIELD_SEC;
            endcase
        end
    end

    // Mode register, time-tracking pipeline and the edited time
    always_comb begin
        set_active_d = !sw0 && sw1;
        trk1_d       = {self_hourH, self_hourL, self_minH,
                        self_minL, self_secH, self_secL};
        trk2_d       = trk1_q;
        manual_d     = manual_q;

        if (!set_active_q) begin
            manual_d = trk2_q;
        end else if (edit_inc || edit_dec) begin
            // Edit uses the field in effect before any coincident select
            case (field_q)
                FIELD_SEC: {manual_d.sec_h, manual_d.sec_l} =
                    bcd_pair_step({manual_q.sec_h, manual_q.sec_l},
                                  SEC_MAX_H, BCD_MAX_L, edit_inc);
                FIELD_MIN: {manual_d.min_h, manual_d.min_l} =
                    bcd_pair_step({manual_q.min_h, manual_q.min_l},
                                  SEC_MAX_H, BCD_MAX_L, edit_inc);
                FIELD_HOUR: {manual_d.hour_h, manual_d.hour_l} =
                    bcd_pair_step({manual_q.hour_h, manual_q.hour_l},
                                  HOUR_MAX_H, HOUR_MAX_L, edit_inc);
                default: manual_d = manual_q;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            set_active_q <= 1'b0;
            trk1_q       <= RST_TIME;
            trk2_q       <= RST_TIME;
            manual_q     <= RST_TIME;
            field_q      <= FIELD_SEC;
        end else begin
            set_active_q <= set_active_d;
            trk1_q       <= trk1_d;
            trk2_q       <= trk2_d;
            manual_q     <= manual_d;
            field_q      <= field_d;
        end
    end

    assign manual_secL  = manual_q.sec_l;
    assign manual_secH  = manual_q.sec_h;
    assign manual_minL  = manual_q.min_l;
    assign manual_minH  = manual_q.min_h;
    assign manual_hourL = manual_q.hour_l;
    assign manual_hourH = manual_q.hour_h;
    assign field_sel    = field_q;

endmodule : manual_time_set
`default_nettype wire

// File: tb/tb_manual_time_set.sv
`default_nettype none
// ============================================================================
// Module      : tb_manual_time_set
// Description : Directed self-checking bench for manual_time_set with
//               DEBOUNCE_CYCLES = 4. Decrement scenarios depend on
//               MANUAL_SET_DEC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_manual_time_set;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw0, sw1;
    logic       btn_sel, btn_inc, btn_dec;
    logic [3:0] self_secL, self_secH, self_minL, self_minH, self_hourL, self_hourH;
    logic [3:0] manual_secL, manual_secH, manual_minL, manual_minH, manual_hourL, manual_hourH;
    logic [1:0] field_sel;
    logic [23:0] man;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign man = {manual_hourH, manual_hourL, manual_minH, manual_minL, manual_secH, manual_secL};

    manual_time_set #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw0          (sw0),
        .sw1          (sw1),
        .btn_sel      (btn_sel),
        .btn_inc      (btn_inc),
        .btn_dec      (btn_dec),
        .self_secL    (self_secL),
        .self_secH    (self_secH),
        .self_minL    (self_minL),
        .self_minH    (self_minH),
        .self_hourL   (self_hourL),
        .self_hourH   (self_hourH),
        .manual_secL  (manual_secL),
        .manual_secH  (manual_secH),
        .manual_minL  (manual_minL),
        .manual_minH  (manual_minH),
        .manual_hourL (manual_hourL),
        .manual_hourH (manual_hourH),
        .field_sel    (field_sel)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_self(input logic [23:0] t);
        {self_hourH, self_hourL, self_minH, self_minL, self_secH, self_secL} = t;
    endtask

    // Hold buttons long enough for one pulse and its update, then release fully
    task automatic press(input logic s, input logic i, input logic d);
        btn_sel = s; btn_inc = i; btn_dec = d;
        tick(8);
        btn_sel = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        tick(8);
    endtask

    // Leave set mode, let the time track t, then re-enter set mode
    task automatic load_time(input logic [23:0] t);
        sw0 = 1'b1; sw1 = 1'b1;
        set_self(t);
        tick(5);
        sw0 = 1'b0;
        tick(2);
    endtask

    task automatic test_reset;
        rst = 1'b1; sw0 = 1'b1; sw1 = 1'b1;
        btn_sel = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        set_self(24'h000000);
        tick(3);
        n_vec++;
        if (man !== 24'h235700) begin
            n_err++; $display("FAIL reset_time: got %h expected %h", man, 24'h235700);
        end
        n_vec++;
        if (field_sel !== 2'd0) begin
            n_err++; $display("FAIL reset_field: got %0d expected %0d", field_sel, 0);
        end
        rst = 1'b0;
    endtask

    task automatic test_tracking;
        set_self(24'h123456);
        tick(2);
        n_vec++;
        if (man !== 24'h235700) begin
            n_err++; $display("FAIL track_latency2: got %h expected %h", man, 24'h235700);
        end
        tick(1);
        n_vec++;
        if (man !== 24'h123456) begin
            n_err++; $display("FAIL track_latency3: got %h expected %h", man, 24'h123456);
        end
        sw0 = 1'b0;
        tick(2);
        set_self(24'h123457);
        tick(5);
        n_vec++;
        if (man !== 24'h123456) begin
            n_err++; $display("FAIL entry_hold: got %h expected %h", man, 24'h123456);
        end
        n_vec++;
        if (field_sel !== 2'd0) begin
            n_err++; $display("FAIL entry_field: got %0d expected %0d", field_sel, 0);
        end
    endtask

    task automatic test_wrap;
        load_time(24'h233459);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (field_sel !== 2'd2) begin
            n_err++; $display("FAIL field_hour: got %0d expected %0d", field_sel, 2);
        end
        press(1'b0, 1'b1, 1'b0);
        n_vec++;
        if (man !== 24'h003459) begin
            n_err++; $display("FAIL hour_wrap: got %h expected %h", man, 24'h003459);
        end
        press(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (field_sel !== 2'd0) begin
            n_err++; $display("FAIL field_wrap: got %0d expected %0d", field_sel, 0);
        end
        press(1'b0, 1'b1, 1'b0);
        n_vec++;
        if (man !== 24'h003400) begin
            n_err++; $display("FAIL sec_wrap: got %h expected %h", man, 24'h003400);
        end
        // Non-BCD seconds digit snaps to 00 on increment
        load_time(24'h12347A);
        press(1'b0, 1'b1, 1'b0);
        n_vec++;
        if (man !== 24'h123400) begin
            n_err++; $display("FAIL invalid_inc: got %h expected %h", man, 24'h123400);
        end
    endtask

    task automatic test_decrement;
`ifdef MANUAL_SET_DEC_EN
        load_time(24'h120030);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (man !== 24'h125930) begin
            n_err++; $display("FAIL min_dec_wrap: got %h expected %h", man, 24'h125930);
        end
        press(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (man !== 24'h125830) begin
            n_err++; $display("FAIL min_dec: got %h expected %h", man, 24'h125830);
        end
        load_time(24'h12347A);
        press(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (man !== 24'h123459) begin
            n_err++; $display("FAIL invalid_dec: got %h expected %h", man, 24'h123459);
        end
`else
        load_time(24'h120030);
        press(1'b0, 1'b0, 1'b1);
        n_vec++;
        if (man !== 24'h120030) begin
            n_err++; $display("FAIL dec_ignored: got %h expected %h", man, 24'h120030);
        end
`endif
    endtask

    task automatic test_debounce;
        load_time(24'h000005);
        for (int i = 0; i < 10; i++) begin
            btn_inc = (i % 2 == 0);
            tick(1);
        end
        btn_inc = 1'b1;
        tick(6);
        n_vec++;
        if (man !== 24'h000005) begin
            n_err++; $display("FAIL debounce_early: got %h expected %h", man, 24'h000005);
        end
        tick(1);
        n_vec++;
        if (man !== 24'h000006) begin
            n_err++; $display("FAIL debounce_edge: got %h expected %h", man, 24'h000006);
        end
        tick(19);
        n_vec++;
        if (man !== 24'h000006) begin
            n_err++; $display("FAIL debounce_hold: got %h expected %h", man, 24'h000006);
        end
        btn_inc = 1'b0;
        tick(8);
    endtask

    task automatic test_simultaneous;
        load_time(24'h000009);
        press(1'b1, 1'b1, 1'b0);
        n_vec++;
        if (man !== 24'h000010) begin
            n_err++; $display("FAIL sel_inc_time: got %h expected %h", man, 24'h000010);
        end
        n_vec++;
        if (field_sel !== 2'd1) begin
            n_err++; $display("FAIL sel_inc_field: got %0d expected %0d", field_sel, 1);
        end
        press(1'b0, 1'b1, 1'b1);
        n_vec++;
`ifdef MANUAL_SET_DEC_EN
        if (man !== 24'h000010) begin
            n_err++; $display("FAIL inc_dec: got %h expected %h", man, 24'h000010);
        end
`else
        if (man !== 24'h000110) begin
            n_err++; $display("FAIL inc_dec: got %h expected %h", man, 24'h000110);
        end
`endif
    endtask

    task automatic test_reset_mid_press;
        sw0 = 1'b0; sw1 = 1'b1;
        btn_inc = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(1);
        n_vec++;
        if (man !== 24'h235700) begin
            n_err++; $display("FAIL midrst_time: got %h expected %h", man, 24'h235700);
        end
        n_vec++;
        if (field_sel !== 2'd0) begin
            n_err++; $display("FAIL midrst_field: got %0d expected %0d", field_sel, 0);
        end
        rst = 1'b0;
        tick(20);
        n_vec++;
        if (man !== 24'h235700) begin
            n_err++; $display("FAIL midrst_held: got %h expected %h", man, 24'h235700);
        end
        btn_inc = 1'b0;
        tick(8);
        press(1'b0, 1'b1, 1'b0);
        n_vec++;
        if (man !== 24'h235701) begin
            n_err++; $display("FAIL midrst_repress: got %h expected %h", man, 24'h235701);
        end
    endtask

    initial begin
        test_reset;
        test_tracking;
        test_wrap;
        test_decrement;
        test_debounce;
        test_simultaneous;
        test_reset_mid_press;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_manual_time_set
`default_nettype wire
